gaussian_window_5x5: RTL and testbench

- Streaming 5x5 window generator; sits directly upstream of the Gaussian blur operator.
- Accepts one raster-order pixel per handshake and keeps the previous four image rows in line buffers.
- Presents each complete 5x5 neighbourhood as a flattened 25-pixel bus with valid/ready, plus an end-of-frame marker.
- Valid-region only (no padding): emits (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows per frame.

---
 rtl/sobel_pkg.sv | 12 +
 rtl/line_buffer.sv | 23 ++
 rtl/gaussian_window_5x5.sv | 137 +++++++++++++
 tb/tb_gaussian_window_5x5.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the 5x5 neighbourhood window and the operators fed by it.
package sobel_pkg;

    localparam int KSIZE = 5;
    localparam int KAREA = KSIZE * KSIZE;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write, shared address.
module line_buffer #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 720
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DWIDTH-1:0]        wr_data,
    output logic [DWIDTH-1:0]        rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/gaussian_window_5x5.sv
// Streaming 5x5 window generator: four line buffers plus a shifting 5x5 register,
// emitting only fully populated (valid-region) windows with valid/ready and end-of-frame.
module gaussian_window_5x5
    import sobel_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DWIDTH-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [KAREA*DWIDTH-1:0] out_window,
    output logic                    out_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(KSIZE - 2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    win_state_t    state;

    logic accept;
    logic row_end;
    logic frame_end;
    logic completing;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign row_end    = (col == COL_LAST);
    assign frame_end  = row_end && (row == ROW_LAST);
    assign completing = accept && (state == RUN) && (col >= COL_FIRST_WIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            state     <= FILL;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (row_end) begin
                    col <= '0;
                    if (frame_end) begin
                        row   <= '0;
                        state <= FILL;
                    end else begin
                        row <= row + 1'b1;
                        if (row == ROW_FILL_LAST) begin
                            state <= RUN;
                        end
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (completing) begin
                out_valid <= 1'b1;
                out_last  <= frame_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // LB0 holds the previous row; each older buffer takes the row its neighbour is about to lose.
    logic [DWIDTH-1:0] lb_rd [KSIZE-1];
    logic [DWIDTH-1:0] lb_wr [KSIZE-1];

    always_comb begin
        lb_wr[0] = in_data;
        for (int unsigned k = 1; k < KSIZE - 1; k++) begin
            lb_wr[k] = lb_rd[k-1];
        end
    end

    for (genvar k = 0; k < KSIZE - 1; k++) begin : g_lb
        line_buffer #(
            .DWIDTH (DWIDTH),
            .DEPTH  (IMG_WIDTH)
        ) u_lb (
            .clock   (clock),
            .wr_en   (accept),
            .addr    (col),
            .wr_data (lb_wr[k]),
            .rd_data (lb_rd[k])
        );
    end

    logic [DWIDTH-1:0] new_col [KSIZE];
    logic [DWIDTH-1:0] win     [KSIZE][KSIZE];

    always_comb begin
        new_col[KSIZE-1] = in_data;
        for (int unsigned r = 0; r < KSIZE - 1; r++) begin
            new_col[r] = lb_rd[KSIZE-2-r];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < KSIZE; r++) begin
                for (int unsigned c = 0; c < KSIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned r = 0; r < KSIZE; r++) begin
                for (int unsigned c = 0; c < KSIZE - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KSIZE-1] <= new_col[r];
            end
        end
    end

    always_comb begin
        out_window = '0;
        for (int unsigned r = 0; r < KSIZE; r++) begin
            for (int unsigned c = 0; c < KSIZE; c++) begin
                out_window[(r*KSIZE+c)*DWIDTH +: DWIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_gaussian_window_5x5.sv
// Scoreboard bench for gaussian_window_5x5 on an 8x6 frame with pixel = row*16+col.
module tb_gaussian_window_5x5;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WB = 25 * DW;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WB-1:0] out_window;
    logic          out_last;

    gaussian_window_5x5 #(
        .DWIDTH     (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_last   (out_last)
    );

    typedef struct {
        logic [WB-1:0] win;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   win_count  = 0;
    bit   sparse     = 0;
    bit   stall      = 0;
    logic prev_valid = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] exp_window(input int rr, input int cc);
        logic [WB-1:0] v;
        v = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                v[(r*5+c)*DW +: DW] = 8'((rr - 4 + r) * 16 + (cc - 4 + c));
            end
        end
        return v;
    endfunction

    // Output side: a window is consumed on a cycle where out_valid && out_ready.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sparse) check("single_cycle_pulse", WB'(prev_valid), WB'(0));
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("window_expected", WB'(sb.size() > 0), WB'(1));
                end else begin
                    e = sb.pop_front();
                    check("window", out_window, e.win);
                    check("last", WB'(out_last), WB'(e.last));
                    win_count++;
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic send_pixel(input int r, input int c);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'(r * 16 + c);
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
        end
        if (!acc) begin
            check("accept_timeout", WB'(acc), WB'(1));
        end else begin
            if (r >= 4 && c >= 4) sb.push_back('{exp_window(r, c), (r == H - 1 && c == W - 1)});
            #1;
            check("valid_after_accept", WB'(out_valid), WB'(r >= 4 && c >= 4));
        end
        in_valid = 1'b0;
        if (sparse) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic stream(input int last_idx);
        logic [WB-1:0] frozen;
        for (int i = 0; i <= last_idx; i++) begin
            send_pixel(i / W, i % W);
            if (stall && i == 4 * W + 4) begin
                out_ready = 1'b0;
                frozen    = exp_window(4, 4);
                repeat (3) begin
                    @(negedge clock);
                    check("bp_in_ready", WB'(in_ready), WB'(0));
                    check("bp_valid_held", WB'(out_valid), WB'(1));
                    check("bp_window_frozen", out_window, frozen);
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic finish_frames(input string tag, input int n_exp);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
        #1;
        check({tag, "_drained"}, WB'(sb.size()), WB'(0));
        check({tag, "_count"}, WB'(win_count), WB'(n_exp));
        win_count = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        check("rst_valid", WB'(out_valid), WB'(0));
        check("rst_last", WB'(out_last), WB'(0));
        check("rst_window", out_window, WB'(0));
        sb.delete();
        win_count = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check("reset_valid", WB'(out_valid), WB'(0));
        check("reset_last", WB'(out_last), WB'(0));
        check("reset_window", out_window, WB'(0));
        check("reset_in_ready", WB'(in_ready), WB'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Two back-to-back frames, continuous input
        stream(W * H - 1);
        stream(W * H - 1);
        finish_frames("two_frames", 16);

        // Backpressure on the first window
        stall = 1'b1;
        stream(W * H - 1);
        stall = 1'b0;
        finish_frames("backpressure", 8);

        // Reset after pixel 0x33, then a clean frame
        stream(3 * W + 3);
        pulse_reset();
        stream(W * H - 1);
        finish_frames("after_reset", 8);

        // Reset while the last window is valid and stalled
        stream(W * H - 2);
        finish_frames("pre_last", 7);
        send_pixel(H - 1, W - 1);
        out_ready = 1'b0;
        check("last_pending_valid", WB'(out_valid), WB'(1));
        check("last_pending_flag", WB'(out_last), WB'(1));
        pulse_reset();
        out_ready = 1'b1;

        // Sparse input
        sparse = 1'b1;
        stream(W * H - 1);
        finish_frames("sparse", 8);
        sparse = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
